// File: rtl/multicycle_mem_responder_if.sv
// Request/response bundle between a cache fill engine (master) and the
// multicycle memory responder (slave).
interface multicycle_mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              data_valid;
  logic              busy;
  logic [3:0]        rd_pending;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy, rd_pending
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy, rd_pending
  );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Word-organised memory with a fixed-latency, fully pipelined read path and
// single-cycle writes; one request accepted per cycle, never back-pressured.
module multicycle_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4
) (
  input logic                         clk,
  input logic                         rst,
  multicycle_mem_responder_if.slave   bus
);
  localparam int DATA_W = 16;
  localparam int WORDS  = 2 ** (ADDR_W - 1);

  logic [DATA_W-1:0] mem_q [WORDS];

  logic [LATENCY:1]  vld_q;
  logic [DATA_W-1:0] dat_q [1:LATENCY];
  logic              data_valid_q;
  logic [DATA_W-1:0] data_out_q;
  logic [3:0]        pend_q;
  logic [3:0]        pend_d;

  logic [ADDR_W-2:0] word_idx;
  logic              rd_issue;
  logic              wr_issue;
  logic              rd_return;
  logic              unused_addr0;

  assign word_idx     = bus.addr[ADDR_W-1:1];
  assign unused_addr0 = bus.addr[0];
  assign rd_issue     = bus.enable && !bus.wr && !rst;
  assign wr_issue     = bus.enable &&  bus.wr && !rst;
  assign rd_return    = vld_q[LATENCY];

  always_comb begin
    pend_d = pend_q;
    unique case ({rd_issue, rd_return})
      2'b10:   pend_d = pend_q + 4'd1;
      2'b01:   pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
  end

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_issue) begin
      mem_q[word_idx] <= bus.data_in;
    end
  end

  // Stage 1 snapshots the word at issue, later stages only shift
  always_ff @(posedge clk) begin
    dat_q[1] <= mem_q[word_idx];
    for (int i = 2; i <= LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      pend_q       <= '0;
    end else begin
      vld_q[1] <= rd_issue;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      // Output stage: data_out holds between returns
      data_valid_q <= rd_return;
      if (rd_return) begin
        data_out_q <= dat_q[LATENCY];
      end
      pend_q <= pend_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rd_pending = pend_q;
  assign bus.busy       = (pend_q != 4'd0);
endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: a LATENCY=4 and a LATENCY=1 instance
// see identical stimulus; returned words are tracked per instance in queues.
module tb_multicycle_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_mem_responder_if #(.ADDR_W(16)) bus4 ();
  multicycle_mem_responder_if #(.ADDR_W(16)) bus1 ();

  multicycle_mem_responder #(.ADDR_W(16), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  multicycle_mem_responder #(.ADDR_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  assign bus1.enable  = bus4.enable;
  assign bus1.wr      = bus4.wr;
  assign bus1.addr    = bus4.addr;
  assign bus1.data_in = bus4.data_in;

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [3:0]  pend;   // expected rd_pending of the LATENCY=4 instance
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb4[$];
  exp_t        sb1[$];
  logic [15:0] mdl_mem [int];
  int          edge_n = 0;
  int          total  = 0;
  int          passes = 0;
  logic        exp_dv4, exp_dv1;
  logic [15:0] exp_do4, exp_do1;

  function automatic vec_t mk(logic r, logic e, logic w, logic [15:0] a,
                              logic [15:0] d, logic [3:0] p);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.addr = a; v.din = d; v.pend = p;
    return v;
  endfunction

  function automatic void add(logic r, logic e, logic w, logic [15:0] a,
                              logic [15:0] d, logic [3:0] p);
    vecs.push_back(mk(r, e, w, a, d, p));
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
  endtask

  task automatic model_edge(input vec_t v);
    if (v.rst) begin
      sb4.delete(); sb1.delete();
      exp_dv4 = 1'b0; exp_do4 = 16'h0000;
      exp_dv1 = 1'b0; exp_do1 = 16'h0000;
    end else begin
      exp_dv4 = 1'b0;
      if (sb4.size() > 0 && sb4[0].due == edge_n) begin
        exp_dv4 = 1'b1; exp_do4 = sb4[0].data; void'(sb4.pop_front());
      end
      exp_dv1 = 1'b0;
      if (sb1.size() > 0 && sb1[0].due == edge_n) begin
        exp_dv1 = 1'b1; exp_do1 = sb1[0].data; void'(sb1.pop_front());
      end
      if (v.en && v.wr) begin
        mdl_mem[int'(v.addr[15:1])] = v.din;
      end else if (v.en) begin
        sb4.push_back('{edge_n + 4, mdl_mem[int'(v.addr[15:1])]});
        sb1.push_back('{edge_n + 1, mdl_mem[int'(v.addr[15:1])]});
      end
    end
  endtask

  task automatic step(input vec_t v);
    rst          = v.rst;
    bus4.enable  = v.en;
    bus4.wr      = v.wr;
    bus4.addr    = v.addr;
    bus4.data_in = v.din;
    @(posedge clk);
    edge_n++;
    model_edge(v);
    @(negedge clk);
    check("data_valid_L4", 16'(bus4.data_valid), 16'(exp_dv4));
    check("data_out_L4",   bus4.data_out, exp_do4);
    check("rd_pending_L4", 16'(bus4.rd_pending), 16'(v.pend));
    check("busy_L4",       16'(bus4.busy), 16'(v.pend != 4'd0));
    check("data_valid_L1", 16'(bus1.data_valid), 16'(exp_dv1));
    check("data_out_L1",   bus1.data_out, exp_do1);
    check("rd_pending_L1", 16'(bus1.rd_pending), 16'(sb1.size()));
    check("busy_L1",       16'(bus1.busy), 16'(sb1.size() != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, then preload the words used below through the bus
    add(1, 0, 0, 16'h0000, 16'h0000, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 16'h1230 + 16'(2*i), 16'hA918 + 16'(i), 0);
    add(0, 1, 1, 16'h0080, 16'h1111, 0);
    // Eight back-to-back reads of one block, then drain
    for (int i = 0; i < 8; i++) add(0, 1, 0, 16'h1230 + 16'(2*i), 16'h0, (i < 3) ? 4'(i+1) : 4'd4);
    add(0, 0, 0, 16'h0, 16'h0, 3);
    add(0, 0, 0, 16'h0, 16'h0, 2);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 0);
    // Read-after-write; addr[0] ignored
    add(0, 1, 1, 16'h0040, 16'hBEEF, 0);
    add(0, 1, 0, 16'h0040, 16'h0, 1);
    add(0, 1, 0, 16'h0041, 16'h0, 2);
    add(0, 0, 0, 16'h0, 16'h0, 2);
    add(0, 0, 0, 16'h0, 16'h0, 2);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 0);
    // Snapshot at issue: later write must not alter an in-flight read
    add(0, 1, 0, 16'h0080, 16'h0, 1);
    add(0, 1, 1, 16'h0080, 16'h2222, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 0);
    add(0, 1, 0, 16'h0080, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 0);
    // Issue gaps reproduce as strobe gaps
    add(0, 1, 0, 16'h1230, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 1, 0, 16'h1232, 16'h0, 2);
    add(0, 1, 0, 16'h1234, 16'h0, 3);
    add(0, 0, 0, 16'h0, 16'h0, 2);
    add(0, 0, 0, 16'h0, 16'h0, 2);
    add(0, 0, 0, 16'h0, 16'h0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 0);
    add(0, 0, 0, 16'h0, 16'h0, 0);

    foreach (vecs[i]) step(vecs[i]);

    // Reset with three reads in flight, plus a write presented during reset
    step(mk(0, 1, 0, 16'h1236, 16'h0, 1));
    step(mk(0, 1, 0, 16'h1238, 16'h0, 2));
    step(mk(0, 1, 0, 16'h123A, 16'h0, 3));
    step(mk(1, 1, 1, 16'h0040, 16'hDEAD, 0));
    for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 16'h0, 16'h0, 0));
    step(mk(0, 1, 0, 16'h0040, 16'h0, 1));
    step(mk(0, 0, 0, 16'h0, 16'h0, 1));
    step(mk(0, 0, 0, 16'h0, 16'h0, 1));
    step(mk(0, 0, 0, 16'h0, 16'h0, 1));
    step(mk(0, 0, 0, 16'h0, 16'h0, 0));

    // Continuous reads: L4 saturates at 4, L1 holds at 1
    for (int i = 0; i < 10; i++)
      step(mk(0, 1, 0, 16'h1230 + 16'(2*(i % 8)), 16'h0, (i < 3) ? 4'(i+1) : 4'd4));
    step(mk(0, 0, 0, 16'h0, 16'h0, 3));
    step(mk(0, 0, 0, 16'h0, 16'h0, 2));
    step(mk(0, 0, 0, 16'h0, 16'h0, 1));
    step(mk(0, 0, 0, 16'h0, 16'h0, 0));
    step(mk(0, 0, 0, 16'h0, 16'h0, 0));

    check("drained_L4", 16'(sb4.size()), 16'd0);
    check("drained_L1", 16'(sb1.size()), 16'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
